// File: rtl/input_route_buffer.sv
// input_route_buffer
// Per-input-port stage in front of the crossbar. Incoming flits are queued
// in a small FIFO together with their next-hop direction. The direction is
// computed once at enqueue time using dimension-order, minimal routing on a
// 3D torus. The head flit goes either to the switch or to the local eject
// port, depending on its stored route.
module input_route_buffer #(
  parameter int FLIT_SIZE    = 82,
  parameter int ROUTE_LEN    = 3,
  parameter int input_Q_size = 5,
  parameter int K_DIM        = 8,
  parameter int COORD_W      = 3,
  parameter int DST_X_LSB    = 64,
  parameter int cur_x        = 0,
  parameter int cur_y        = 0,
  parameter int cur_z        = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] in,
  input  logic                 in_valid,
  output logic                 in_avail,
  output logic [FLIT_SIZE-1:0] out,
  output logic [ROUTE_LEN-1:0] route_out,
  output logic                 out_valid,
  input  logic                 out_avail,
  output logic [FLIT_SIZE-1:0] eject_out,
  output logic                 eject_valid,
  input  logic                 eject_ready,
  output logic                 credit_out,
  output logic                 route_err
);

  localparam int PTR_W = (input_Q_size > 1) ? $clog2(input_Q_size) : 1;
  localparam int CNT_W = $clog2(input_Q_size + 1);

  localparam logic [ROUTE_LEN-1:0] R_XPOS  = ROUTE_LEN'(1);
  localparam logic [ROUTE_LEN-1:0] R_YPOS  = ROUTE_LEN'(2);
  localparam logic [ROUTE_LEN-1:0] R_ZPOS  = ROUTE_LEN'(3);
  localparam logic [ROUTE_LEN-1:0] R_XNEG  = ROUTE_LEN'(4);
  localparam logic [ROUTE_LEN-1:0] R_YNEG  = ROUTE_LEN'(5);
  localparam logic [ROUTE_LEN-1:0] R_ZNEG  = ROUTE_LEN'(6);
  localparam logic [ROUTE_LEN-1:0] R_EJECT = ROUTE_LEN'(7);

  logic [FLIT_SIZE-1:0] flit_mem  [input_Q_size];
  logic [ROUTE_LEN-1:0] route_mem [input_Q_size];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [COORD_W-1:0] dst_x;
  logic [COORD_W-1:0] dst_y;
  logic [COORD_W-1:0] dst_z;
  int                 dist_x;
  int                 dist_y;
  int                 dist_z;
  logic               range_bad;
  logic [ROUTE_LEN-1:0] in_route;

  logic empty;
  logic do_enq;
  logic do_deq;
  logic [ROUTE_LEN-1:0] head_route;

  // Forward distance around the ring, (dst - cur) mod K_DIM.
  // Only meaningful when dst is already known to be in range.
  function automatic int ring_dist(input logic [COORD_W-1:0] dst, input int cur);
    int d;
    d = int'(dst) - cur;
    if (d < 0) d = d + K_DIM;
    return d;
  endfunction

  // Pointers run 0..input_Q_size-1 and wrap explicitly, so the depth need
  // not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(input_Q_size - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Route the incoming flit: X, then Y, then Z. A tie at half the ring goes
  // positive. An out-of-range coordinate is sunk locally as an eject.
  always_comb begin
    dst_x     = in[DST_X_LSB +: COORD_W];
    dst_y     = in[DST_X_LSB + COORD_W +: COORD_W];
    dst_z     = in[DST_X_LSB + 2*COORD_W +: COORD_W];
    range_bad = (int'(dst_x) >= K_DIM) || (int'(dst_y) >= K_DIM) ||
                (int'(dst_z) >= K_DIM);
    dist_x    = ring_dist(dst_x, cur_x);
    dist_y    = ring_dist(dst_y, cur_y);
    dist_z    = ring_dist(dst_z, cur_z);
    in_route  = R_EJECT;
    if (range_bad)        in_route = R_EJECT;
    else if (dist_x != 0) in_route = (dist_x <= K_DIM/2) ? R_XPOS : R_XNEG;
    else if (dist_y != 0) in_route = (dist_y <= K_DIM/2) ? R_YPOS : R_YNEG;
    else if (dist_z != 0) in_route = (dist_z <= K_DIM/2) ? R_ZPOS : R_ZNEG;
  end

  // Head presentation and handshakes. Everything comes from registered
  // state, so there is no combinational path from in to out.
  always_comb begin
    empty       = (count == '0);
    in_avail    = (count != CNT_W'(input_Q_size));
    head_route  = route_mem[rd_ptr];
    out         = flit_mem[rd_ptr];
    eject_out   = flit_mem[rd_ptr];
    route_out   = head_route;
    out_valid   = !empty && (head_route != R_EJECT);
    eject_valid = !empty && (head_route == R_EJECT);
    do_enq      = in_valid && in_avail;
    do_deq      = (out_valid && out_avail) || (eject_valid && eject_ready);
  end

  // Pointers, occupancy, credit pulse and the sticky routing-error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      credit_out <= 1'b0;
      route_err  <= 1'b0;
    end else begin
      if (do_enq) wr_ptr <= next_ptr(wr_ptr);
      if (do_deq) rd_ptr <= next_ptr(rd_ptr);
      if (do_enq && !do_deq)      count <= count + 1'b1;
      else if (!do_enq && do_deq) count <= count - 1'b1;
      credit_out <= do_deq;
      if (do_enq && range_bad) route_err <= 1'b1;
    end
  end

  // Flit and route storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      flit_mem[wr_ptr]  <= in;
      route_mem[wr_ptr] <= in_route;
    end
  end

endmodule

// File: tb/tb_input_route_buffer.sv
// Directed testbench for input_route_buffer. The instance uses 4-bit
// coordinate fields on an 8-ring torus, so out-of-range destinations can be
// expressed.
module tb_input_route_buffer;

  localparam int FW = 82;
  localparam int RL = 3;

  logic          clk;
  logic          rst;
  logic [FW-1:0] in;
  logic          in_valid;
  logic          in_avail;
  logic [FW-1:0] out;
  logic [RL-1:0] route_out;
  logic          out_valid;
  logic          out_avail;
  logic [FW-1:0] eject_out;
  logic          eject_valid;
  logic          eject_ready;
  logic          credit_out;
  logic          route_err;

  int checks = 0;
  int errors = 0;

  input_route_buffer #(
    .FLIT_SIZE(82), .ROUTE_LEN(3), .input_Q_size(5), .K_DIM(8),
    .COORD_W(4), .DST_X_LSB(64), .cur_x(0), .cur_y(0), .cur_z(0)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_avail(in_avail),
    .out(out), .route_out(route_out), .out_valid(out_valid),
    .out_avail(out_avail), .eject_out(eject_out), .eject_valid(eject_valid),
    .eject_ready(eject_ready), .credit_out(credit_out), .route_err(route_err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [FW-1:0] make_flit(input int x, input int y, input int z,
                                               input int payload);
    logic [FW-1:0] f;
    f = '0;
    f[31:0]  = payload;
    f[67:64] = x[3:0];
    f[71:68] = y[3:0];
    f[75:72] = z[3:0];
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [FW-1:0] flit, input logic valid);
    in       = flit;
    in_valid = valid;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One flit through an idle buffer to the switch: one cycle to the head,
  // then dequeued by out_avail, credit the cycle after.
  task automatic route_one(input int x, input int y, input int z, input int p,
                           input int exp_route, input string tag);
    logic [FW-1:0] f;
    f = make_flit(x, y, z, p);
    apply_stimulus(f, 1'b1);
    step();
    apply_stimulus('0, 1'b0);
    check_output({tag, "_valid"}, 128'(out_valid), 128'(1));
    check_output({tag, "_route"}, 128'(route_out), 128'(exp_route));
    check_output({tag, "_flit"},  128'(out), 128'(f));
    step();
    check_output({tag, "_credit"}, 128'(credit_out), 128'(1));
    check_output({tag, "_drained"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    logic [FW-1:0] f;
    rst         = 1'b0;
    in          = '0;
    in_valid    = 1'b0;
    out_avail   = 1'b0;
    eject_ready = 1'b0;
    step();
    step();
    check_output("rst_in_avail",    128'(in_avail),    128'(1));
    check_output("rst_out_valid",   128'(out_valid),   128'(0));
    check_output("rst_eject_valid", 128'(eject_valid), 128'(0));
    check_output("rst_credit",      128'(credit_out),  128'(0));
    check_output("rst_route_err",   128'(route_err),   128'(0));
    rst = 1'b1;
    step();

    // Routing cases through the switch port.
    out_avail = 1'b1;
    route_one(3, 0, 0, 1, 1, "x3_xpos");
    route_one(5, 0, 0, 2, 4, "x5_xneg");
    route_one(4, 0, 0, 3, 1, "x4_tie");
    route_one(0, 6, 2, 4, 5, "y6_yneg");
    route_one(0, 2, 0, 5, 2, "y2_ypos");
    route_one(0, 0, 3, 6, 3, "z3_zpos");
    route_one(0, 0, 7, 7, 6, "z7_zneg");
    route_one(0, 0, 4, 8, 3, "z4_tie");

    // Local destination goes to the eject port and waits for the sink.
    out_avail = 1'b0;
    f = make_flit(0, 0, 0, 9);
    apply_stimulus(f, 1'b1);
    step();
    apply_stimulus('0, 1'b0);
    check_output("ej_valid",     128'(eject_valid), 128'(1));
    check_output("ej_out_valid", 128'(out_valid),   128'(0));
    check_output("ej_flit",      128'(eject_out),   128'(f));
    step();
    check_output("ej_held",      128'(eject_valid), 128'(1));
    check_output("ej_no_credit", 128'(credit_out),  128'(0));
    eject_ready = 1'b1;
    step();
    check_output("ej_credit",    128'(credit_out),  128'(1));
    check_output("ej_drained",   128'(eject_valid), 128'(0));
    eject_ready = 1'b0;
    step();
    check_output("ej_credit_end", 128'(credit_out), 128'(0));

    // Fill to capacity with the switch stalled.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(make_flit(3, 0, 0, 10 + i), 1'b1);
      step();
      check_output($sformatf("fill%0d_in_avail", i), 128'(in_avail),
                   128'((i < 4) ? 1 : 0));
    end
    apply_stimulus(make_flit(3, 0, 0, 15), 1'b1);
    step();
    step();
    check_output("full_in_avail", 128'(in_avail),  128'(0));
    check_output("full_head",     128'(out),       128'(make_flit(3, 0, 0, 10)));
    apply_stimulus('0, 1'b0);

    // Drain in order, one credit per flit.
    out_avail = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("drain%0d_valid", i), 128'(out_valid), 128'(1));
      check_output($sformatf("drain%0d_flit", i), 128'(out),
                   128'(make_flit(3, 0, 0, 10 + i)));
      step();
      check_output($sformatf("drain%0d_credit", i), 128'(credit_out), 128'(1));
      check_output($sformatf("drain%0d_in_avail", i), 128'(in_avail), 128'(1));
    end
    check_output("drain_empty", 128'(out_valid), 128'(0));
    step();
    check_output("drain_credit_end", 128'(credit_out), 128'(0));

    // Streaming at one flit per cycle across several pointer wraps.
    apply_stimulus(make_flit(2, 0, 0, 100), 1'b1);
    step();
    for (int i = 1; i <= 20; i++) begin
      check_output($sformatf("stream%0d_flit", i), 128'(out),
                   128'(make_flit(2, 0, 0, 100 + i - 1)));
      check_output($sformatf("stream%0d_valid", i), 128'(out_valid), 128'(1));
      apply_stimulus(make_flit(2, 0, 0, 100 + i), 1'b1);
      step();
      check_output($sformatf("stream%0d_credit", i), 128'(credit_out), 128'(1));
    end
    apply_stimulus('0, 1'b0);
    check_output("stream_last", 128'(out), 128'(make_flit(2, 0, 0, 120)));
    step();
    check_output("stream_empty", 128'(out_valid), 128'(0));

    // Out-of-range destination is ejected and flags a sticky error.
    out_avail = 1'b0;
    f = make_flit(9, 0, 0, 200);
    apply_stimulus(f, 1'b1);
    step();
    apply_stimulus('0, 1'b0);
    check_output("bad_eject",     128'(eject_valid), 128'(1));
    check_output("bad_out_valid", 128'(out_valid),   128'(0));
    check_output("bad_err",       128'(route_err),   128'(1));
    eject_ready = 1'b1;
    step();
    eject_ready = 1'b0;
    check_output("bad_credit",    128'(credit_out),  128'(1));
    check_output("bad_err_hold",  128'(route_err),   128'(1));
    apply_stimulus(make_flit(3, 0, 0, 201), 1'b1);
    step();
    apply_stimulus(make_flit(3, 0, 0, 202), 1'b1);
    step();
    check_output("err_sticky",    128'(route_err),   128'(1));
    check_output("pre_rst_valid", 128'(out_valid),   128'(1));

    // Asynchronous reset mid-stream, checked before the next clock edge.
    #2;
    rst = 1'b0;
    #1;
    check_output("arst_err",       128'(route_err),   128'(0));
    check_output("arst_out_valid", 128'(out_valid),   128'(0));
    check_output("arst_eject",     128'(eject_valid), 128'(0));
    check_output("arst_in_avail",  128'(in_avail),    128'(1));
    check_output("arst_credit",    128'(credit_out),  128'(0));
    apply_stimulus('0, 1'b0);
    step();
    rst = 1'b1;
    step();
    check_output("post_rst_empty", 128'(out_valid), 128'(0));
    check_output("post_rst_err",   128'(route_err), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
